mul_div_unit: RTL and testbench

//   Multi-cycle signed 32x32 multiply / 32/32 divide unit in the ALU stage of the data path.
//   - Operand A comes from the Y register; operand B from the bus.
//   - The 64-bit result is written into Z: high half into ZHigh, low half into ZLow.
//   - The control unit pulses start, then holds the step until done, before asserting

---
 rtl/mul_div_unit.sv | 177 +++++++++++++++++
 tb/tb_mul_div_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (restoring) unit.
// One iteration per clock, a sign-fix step, then a one-cycle done pulse.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic               op,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic [2*WIDTH-1:0] z_out
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX,
    DONE
  } state_t;

  state_t             state_q;
  logic               op_q;
  logic               negA_q;
  logic               negB_q;
  logic               dbzPend_q;
  logic               busy_q;
  logic               done_q;
  logic               divZero_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH:0]     hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic [WIDTH-1:0]   m_q;
  logic               qm1_q;
  logic [2*WIDTH-1:0] z_q;

  logic [WIDTH-1:0]   absA;
  logic [WIDTH-1:0]   absB;
  logic [WIDTH:0]     mExt;
  logic [WIDTH:0]     boothSum;
  logic [WIDTH:0]     hiBooth_d;
  logic [WIDTH-1:0]   loBooth_d;
  logic               qm1Booth_d;
  logic [WIDTH:0]     remShift;
  logic [WIDTH:0]     remDiff;
  logic [WIDTH:0]     hiDiv_d;
  logic [WIDTH-1:0]   loDiv_d;
  logic [WIDTH-1:0]   quotFix;
  logic [WIDTH-1:0]   remFix;
  logic [2*WIDTH-1:0] result_d;

  assign absA = op_a[WIDTH-1] ? -op_a : op_a;
  assign absB = op_b[WIDTH-1] ? -op_b : op_b;

  // The Booth high half carries one guard bit so that subtracting a
  // multiplicand of -2^(WIDTH-1) cannot overflow.
  always_comb begin
    mExt     = {m_q[WIDTH-1], m_q};
    boothSum = hi_q;
    case ({lo_q[0], qm1_q})
      2'b01:   boothSum = hi_q + mExt;
      2'b10:   boothSum = hi_q - mExt;
      default: boothSum = hi_q;
    endcase
    hiBooth_d  = {boothSum[WIDTH], boothSum[WIDTH:1]};
    loBooth_d  = {boothSum[0], lo_q[WIDTH-1:1]};
    qm1Booth_d = lo_q[0];
  end

  always_comb begin
    remShift = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
    remDiff  = remShift - {1'b0, m_q};
    hiDiv_d  = remShift;
    loDiv_d  = {lo_q[WIDTH-2:0], 1'b0};
    if (!remDiff[WIDTH]) begin
      hiDiv_d = remDiff;
      loDiv_d = {lo_q[WIDTH-2:0], 1'b1};
    end
  end

  always_comb begin
    quotFix  = (negA_q ^ negB_q) ? -lo_q : lo_q;
    remFix   = negA_q ? -hi_q[WIDTH-1:0] : hi_q[WIDTH-1:0];
    result_d = {hi_q[WIDTH-1:0], lo_q};
    if (dbzPend_q)
      result_d = {lo_q, {WIDTH{1'b1}}};
    else if (op_q)
      result_d = {remFix, quotFix};
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= IDLE;
      op_q      <= 1'b0;
      negA_q    <= 1'b0;
      negB_q    <= 1'b0;
      dbzPend_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divZero_q <= 1'b0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      m_q       <= '0;
      qm1_q     <= 1'b0;
      z_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q      <= op;
            negA_q    <= op_a[WIDTH-1];
            negB_q    <= op_b[WIDTH-1];
            divZero_q <= 1'b0;
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            hi_q      <= '0;
            qm1_q     <= 1'b0;
            dbzPend_q <= 1'b0;
            if (op) begin
              m_q <= absB;
              if (op_b == '0) begin
                // Keep the raw dividend; it is reported as the high half.
                lo_q      <= op_a;
                dbzPend_q <= 1'b1;
                state_q   <= FIX;
              end else begin
                lo_q    <= absA;
                state_q <= ITER;
              end
            end else begin
              m_q     <= op_a;
              lo_q    <= op_b;
              state_q <= ITER;
            end
          end
        end
        ITER: begin
          if (op_q) begin
            hi_q <= hiDiv_d;
            lo_q <= loDiv_d;
          end else begin
            hi_q  <= hiBooth_d;
            lo_q  <= loBooth_d;
            qm1_q <= qm1Booth_d;
          end
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1))
            state_q <= FIX;
        end
        FIX: begin
          z_q       <= result_d;
          divZero_q <= dbzPend_q;
          busy_q    <= 1'b0;
          done_q    <= 1'b1;
          state_q   <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = divZero_q;
  assign z_out       = z_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed operations push expected results,
// a monitor pops and compares them whenever done is seen.
module tb_mul_div_unit;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           clr;
  logic           start;
  logic           op;
  logic [W-1:0]   opA;
  logic [W-1:0]   opB;
  logic           busy;
  logic           done;
  logic           divByZero;
  logic [2*W-1:0] zOut;

  typedef struct {
    string        name;
    logic [63:0]  expZ;
    logic         expDbz;
    int           expLat;
    int           e0Cycle;
  } item_t;

  item_t sb[$];
  item_t monItem;
  int    checks = 0;
  int    errors = 0;
  int    cycleCnt = 0;
  logic  prevDone = 1'b0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .clr         (clr),
    .start       (start),
    .op          (op),
    .op_a        (opA),
    .op_b        (opB),
    .busy        (busy),
    .done        (done),
    .div_by_zero (divByZero),
    .z_out       (zOut)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt++;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (clr === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: got done=1, expected no pending op");
      end else begin
        monItem = sb.pop_front();
        checkOutput({monItem.name, "_z"}, zOut, monItem.expZ);
        checkOutput({monItem.name, "_dbz"}, 64'(divByZero), 64'(monItem.expDbz));
        checkOutput({monItem.name, "_latency"}, 64'(cycleCnt - monItem.e0Cycle),
                    64'(monItem.expLat));
        checkOutput({monItem.name, "_pulse"}, 64'(prevDone), 64'd0);
      end
    end
    prevDone = done;
  end

  task automatic applyStimulus(input string name, input logic opSel,
                               input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [63:0] expZ, input logic expDbz,
                               input int expLat, input int pulseAt);
    item_t it;
    int    busyCnt;
    int    idx;
    bit    seen;
    @(negedge clk);
    op    = opSel;
    opA   = a;
    opB   = b;
    start = 1'b1;
    it.name    = name;
    it.expZ    = expZ;
    it.expDbz  = expDbz;
    it.expLat  = expLat;
    it.e0Cycle = cycleCnt + 1;
    sb.push_back(it);
    @(negedge clk);
    start = 1'b0;
    op    = 1'b1;
    opA   = $urandom;
    opB   = '0;
    checkOutput({name, "_dbz_cleared"}, 64'(divByZero), 64'd0);
    busyCnt = 0;
    idx     = 0;
    seen    = 1'b0;
    while (!seen && idx < 60) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) busyCnt++;
        start = (pulseAt != 0 && idx == pulseAt - 1);
        idx++;
        @(negedge clk);
      end
    end
    start = 1'b0;
    if (!seen) begin
      errors++;
      checks++;
      $display("[TB] FAIL %s_timeout: got no done in 60 cycles, expected done", name);
      sb.delete();
    end else begin
      checkOutput({name, "_busy_cycles"}, 64'(busyCnt), 64'(expLat));
      checkOutput({name, "_busy_at_done"}, 64'(busy), 64'd0);
    end
  endtask

  task automatic applyAbort();
    @(negedge clk);
    op    = 1'b1;
    opA   = 32'd1000;
    opB   = 32'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    @(posedge clk);
    #2 clr = 1'b0;
    #1;
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_done", 64'(done), 64'd0);
    checkOutput("abort_dbz", 64'(divByZero), 64'd0);
    checkOutput("abort_z", zOut, 64'd0);
    @(negedge clk);
    clr = 1'b1;
  endtask

  initial begin
    clr   = 1'b0;
    start = 1'b0;
    op    = 1'b0;
    opA   = '0;
    opB   = '0;
    #12;
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_dbz", 64'(divByZero), 64'd0);
    checkOutput("reset_z", zOut, 64'd0);
    @(negedge clk);
    clr = 1'b1;

    applyStimulus("mul_7_m3", 1'b0, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 33, 0);
    applyStimulus("mul_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000,
                  64'h4000_0000_0000_0000, 1'b0, 33, 0);
    applyStimulus("mul_m1_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 33, 0);
    applyStimulus("mul_m1_m1", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001,
                  1'b0, 33, 0);
    applyStimulus("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 33, 0);
    applyStimulus("div_100_7", 1'b1, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 1'b0, 33, 0);
    applyStimulus("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 1'b0, 33, 0);
    applyStimulus("div_5_0", 1'b1, 32'd5, 32'd0, 64'h0000_0005_FFFF_FFFF, 1'b1, 1, 0);
    repeat (3) @(negedge clk);
    checkOutput("dbz_hold", 64'(divByZero), 64'd1);
    checkOutput("z_hold", zOut, 64'h0000_0005_FFFF_FFFF);
    applyStimulus("mul_after_dbz", 1'b0, 32'd3, 32'd4, 64'h0000_0000_0000_000C, 1'b0, 33, 0);
    applyStimulus("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000,
                  1'b0, 33, 0);
    applyStimulus("mul_repulse", 1'b0, 32'd6, 32'd7, 64'h0000_0000_0000_002A, 1'b0, 33, 5);
    applyAbort();
    applyStimulus("mul_after_clr", 1'b0, 32'h1234_5678, 32'h10, 64'h0000_0001_2345_6780,
                  1'b0, 33, 0);

    repeat (4) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
